// File: rtl/efb_cmd_i2c_tx.sv
// efb_cmd_i2c_tx: I2C single-byte write initiator (START, {DEV_ADDR,W}, command byte, STOP) for the EFB UFM command port
module efb_cmd_i2c_tx #(
    parameter int         CLK_DIV  = 16,
    parameter logic [6:0] DEV_ADDR = 7'h40
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       req_i,
    input  logic [7:0] cmd_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o
);
    localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TOP       = CW'(CLK_DIV - 1);
    localparam logic [7:0]    ADDR_BYTE = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    q, q_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    sr, sr_n;
    logic          nack_f, nack_f_n;
    logic          done_n, nack_n;
    logic [1:0]    scl_sync, sda_sync;
    logic          scl_s, sda_s, slot, at_top, tick, tx_bit;

    assign scl_s  = scl_sync[1];
    assign sda_s  = sda_sync[1];
    assign slot   = state inside {ADDR, AACK, DATA, DACK, STOP};
    assign at_top = cnt == TOP;
    assign tick   = at_top && !(slot && q[1] && !scl_s);
    assign tx_bit = (state == ADDR) ? ADDR_BYTE[~bit_cnt] : sr[7];
    assign busy_o = state != IDLE;

    // Bring the open-drain bus levels into the clk_i domain
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

    // Sequencer state, quarter timing, shift register and completion flags
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state   <= IDLE;
            cnt     <= '0;
            q       <= 2'd0;
            bit_cnt <= 3'd0;
            sr      <= 8'h00;
            nack_f  <= 1'b0;
            done_o  <= 1'b0;
            nack_o  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            q       <= q_n;
            bit_cnt <= bit_n;
            sr      <= sr_n;
            nack_f  <= nack_f_n;
            done_o  <= done_n;
            nack_o  <= nack_n;
        end
    end

    // Quarter counter: idle at 0, saturates while a stretching target holds SCL low
    always_comb begin
        cnt_n = (state == IDLE || tick) ? '0 : at_top ? cnt : cnt + CW'(1);
    end

    // Next-state logic: advance one quarter per tick, bytes MSB first, ACK sampled on the slot's last tick
    always_comb begin
        state_n  = state;
        q_n      = q;
        bit_n    = bit_cnt;
        sr_n     = sr;
        nack_f_n = nack_f;
        done_n   = 1'b0;
        nack_n   = 1'b0;
        if (state == IDLE) begin
            if (req_i) begin
                state_n  = START;
                sr_n     = cmd_i;
                nack_f_n = 1'b0;
                q_n      = 2'd0;
                bit_n    = 3'd0;
            end
        end else if (tick) begin
            q_n = q + 2'd1;
            case (state)
                START: if (q == 2'd1) begin
                    q_n     = 2'd0;
                    state_n = ADDR;
                end
                ADDR, DATA: if (q == 2'd3) begin
                    bit_n = bit_cnt + 3'd1;
                    if (state == DATA) sr_n = {sr[6:0], 1'b0};
                    if (bit_cnt == 3'd7) state_n = (state == ADDR) ? AACK : DACK;
                end
                AACK: if (q == 2'd3) begin
                    nack_f_n = sda_s;
                    state_n  = sda_s ? STOP : DATA;
                end
                DACK: if (q == 2'd3) begin
                    nack_f_n = sda_s;
                    state_n  = STOP;
                end
                STOP: if (q == 2'd3) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    nack_n  = nack_f;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Line drivers: SCL low in the first half of each slot, SDA per START/bit/STOP phase
    always_comb begin
        scl_oe_o = slot && !q[1];
        sda_oe_o = (state == START) ? (q == 2'd1) :
                   (state == ADDR || state == DATA) ? ~tx_bit :
                   (state == STOP) ? (q != 2'd3) : 1'b0;
    end
endmodule

// File: tb/tb_efb_cmd_i2c_tx.sv
// tb_efb_cmd_i2c_tx: directed bench with a timeline model of the I2C write and a pull-up/slave bus model
module tb_efb_cmd_i2c_tx;
    localparam int CD = 4;

    logic       clk_i = 1'b0;
    logic       resetn_i = 1'b0;
    logic       req_i = 1'b0;
    logic [7:0] cmd_i = 8'h00;
    logic       scl_i, sda_i;
    logic       scl_oe_o, sda_oe_o, busy_o, done_o, nack_o;
    logic       stretch = 1'b0;
    logic       slave_on = 1'b0;
    logic       slave_ack;
    logic [7:0] m_cmd = 8'h00;
    logic       m_ack = 1'b1;
    logic       m_str = 1'b0;
    int         checks = 0;
    int         errors = 0;

    int          falls = 0;
    logic        scl_oe_q = 1'b0;
    logic        scl_b_q = 1'b1;
    logic        busy_q = 1'b0;
    logic [31:0] cap = 32'h0;
    int          ncap = 0;

    always #5 clk_i = ~clk_i;

    assign scl_i     = ~scl_oe_o & ~stretch;
    assign sda_i     = ~sda_oe_o & ~slave_ack;
    assign slave_ack = slave_on && busy_o && (falls == 9 || falls == 18);

    efb_cmd_i2c_tx #(.CLK_DIV(CD), .DEV_ADDR(7'h40)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .cmd_i(cmd_i),
        .scl_i(scl_i), .sda_i(sda_i), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o),
        .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o)
    );

    // Slave: counts SCL falls; the 9th and 18th begin the ACK slots
    always @(posedge clk_i) begin
        scl_oe_q <= scl_oe_o;
        if (!busy_o) falls <= 0;
        else if (scl_oe_o && !scl_oe_q) falls <= falls + 1;
    end

    // Bus monitor: SDA captured on each SCL rise of a transaction
    always @(posedge clk_i) begin
        scl_b_q <= scl_i;
        busy_q  <= busy_o;
        if (busy_o && !busy_q) begin
            cap  <= 32'h0;
            ncap <= 0;
        end else if (busy_o && scl_i && !scl_b_q) begin
            cap  <= {cap[30:0], sda_i};
            ncap <= ncap + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {scl_oe, sda_oe, busy, done, nack} t cycles after the accepting edge
    function automatic logic [4:0] model(input int t);
        int n, tt, qn, r, s, ph;
        logic [7:0] b;
        n  = m_ack ? 78 : 42;
        tt = (!m_str || t <= 83) ? t : (t <= 102 ? 83 : t - 19);
        if (tt > n * CD) return 5'b0;
        if (tt == n * CD) return {4'b0001, ~m_ack};
        qn = tt / CD;
        if (qn < 2) return {1'b0, qn == 1, 1'b1, 2'b00};
        r  = qn - 2;
        s  = r / 4;
        ph = r % 4;
        if (s == (n - 2) / 4 - 1) return {ph < 2, ph < 3, 1'b1, 2'b00};
        if (s == 8 || s == 17) return {ph < 2, 1'b0, 1'b1, 2'b00};
        b = (s < 8) ? 8'h80 : m_cmd;
        return {ph < 2, ~b[(s < 8) ? 7 - s : 16 - s], 1'b1, 2'b00};
    endfunction

    task automatic run(input logic [7:0] cmd, input logic ack, input logic str, input logic rep,
                       input int exp_done, input logic exp_rst, input int stop_at);
        int dt, nd, tmax;
        logic [4:0] e;
        m_cmd = cmd; m_ack = ack; m_str = str; slave_on = ack;
        dt = -1; nd = 0;
        tmax = (stop_at >= 0) ? stop_at : exp_done + 3;
        @(negedge clk_i);
        cmd_i = cmd;
        req_i = 1'b1;
        @(posedge clk_i);
        for (int t = 0; t <= tmax; t++) begin
            @(negedge clk_i);
            if (t == 0) begin req_i = 1'b0; cmd_i = 8'h00; end
            if (rep && t == 49) req_i = 1'b1;
            if (rep && t == 50) req_i = 1'b0;
            if (str && t == 80) stretch = 1'b1;
            if (str && t == 100) stretch = 1'b0;
            e = model(t);
            chk("scl_oe", 32'(scl_oe_o), 32'(e[4]));
            chk("sda_oe", 32'(sda_oe_o), 32'(e[3]));
            chk("busy", 32'(busy_o), 32'(e[2]));
            chk("done", 32'(done_o), 32'(e[1]));
            chk("nack", 32'(nack_o), 32'(e[0]));
            if (done_o) begin nd++; dt = t; end
        end
        if (stop_at >= 0) return;
        chk("done_time", 32'(dt), 32'(exp_done));
        chk("done_count", 32'(nd), 32'd1);
        if (ack) begin
            chk("bit_count", 32'(ncap), 32'd19);
            chk("addr_byte", 32'(cap[18:11]), 32'h80);
            chk("addr_ack", 32'(cap[10]), 32'd0);
            chk("data_byte", 32'(cap[9:2]), 32'(cmd));
            chk("data_ack", 32'(cap[1]), 32'd0);
            chk("ufm_rst", 32'(cap[9:2] != 8'hFF), 32'(exp_rst));
        end else begin
            chk("bit_count", 32'(ncap), 32'd10);
            chk("addr_byte", 32'(cap[9:2]), 32'h80);
            chk("addr_nack", 32'(cap[1]), 32'd1);
        end
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_scl_oe", 32'(scl_oe_o), 32'd0);
            chk("rst_sda_oe", 32'(sda_oe_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_nack", 32'(nack_o), 32'd0);
        end
        resetn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        run(8'hFF, 1'b1, 1'b0, 1'b0, 312, 1'b0, -1);
        run(8'hE0, 1'b1, 1'b0, 1'b0, 312, 1'b1, -1);
        run(8'hA5, 1'b0, 1'b0, 1'b0, 168, 1'b1, -1);
        run(8'hFF, 1'b1, 1'b1, 1'b0, 331, 1'b0, -1);
        run(8'h3C, 1'b1, 1'b0, 1'b1, 312, 1'b1, -1);
        run(8'hFF, 1'b1, 1'b0, 1'b0, 312, 1'b0, 99);
        @(posedge clk_i);
        #1 resetn_i = 1'b0;
        #1;
        chk("mid_rst_scl_oe", 32'(scl_oe_o), 32'd0);
        chk("mid_rst_sda_oe", 32'(sda_oe_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        repeat (3) begin
            @(negedge clk_i);
            chk("mid_rst_done", 32'(done_o), 32'd0);
        end
        resetn_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("post_rst_done", 32'(done_o), 32'd0);
            chk("post_rst_busy", 32'(busy_o), 32'd0);
        end
        run(8'hFF, 1'b1, 1'b0, 1'b0, 312, 1'b0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
